// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Contents:
//   md_op_e             operation encodings carried on the op port
//   MUL_CYCLES_DEF      default busy length of mult/multu
//   DIV_CYCLES_DEF      default busy length of div/divu
//   md_state_e          control state encoding
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/mul_div_unit_md_arith.sv
// Combinational arithmetic core of the multiply/divide unit.
// Ports:
//   op        in   3   operation select (md_op_e encoding)
//   rs_data   in  32   dividend / multiplicand
//   rt_data   in  32   divisor / multiplier
//   hi_res    out 32   upper product word, or remainder
//   lo_res    out 32   lower product word, or quotient
//   div_zero  out  1   div/divu with a zero divisor; the result is meaningless
module md_arith
  import mul_div_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_div;
  logic        is_sdiv;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  assign is_div   = (op == MD_DIV) || (op == MD_DIVU);
  assign is_sdiv  = (op == MD_DIV);
  assign div_zero = is_div && (rt_data == 32'd0);

  // A single unsigned divider serves both flavours: signed division runs on
  // magnitudes and the signs are restored afterwards. The magnitude of
  // 0x80000000 is still representable as an unsigned 32-bit value, which is
  // what makes 0x80000000 / -1 come out as 0x80000000 without special casing.
  always_comb begin
    num = rs_data;
    den = rt_data;
    if (is_sdiv) begin
      if (rs_data[31]) num = 32'd0 - rs_data;
      if (rt_data[31]) den = 32'd0 - rt_data;
    end
    if (den == 32'd0) den = 32'd1;  // keeps the divider defined; result is discarded
  end

  assign quo   = num / den;
  assign rem   = num % den;
  assign quo_s = (rs_data[31] ^ rt_data[31]) ? (32'd0 - quo) : quo;
  assign rem_s = rs_data[31] ? (32'd0 - rem) : rem;

  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      MD_MULT:  {hi_res, lo_res} = prod_s;
      MD_MULTU: {hi_res, lo_res} = prod_u;
      MD_DIV:   begin hi_res = rem_s; lo_res = quo_s; end
      MD_DIVU:  begin hi_res = rem;   lo_res = quo;   end
      default:  begin hi_res = 32'd0; lo_res = 32'd0; end
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is produced at the start edge into a shadow register and held
// back until the busy window closes, mimicking a slow iterative unit.
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   mult/multu/div/divu issue pulse
//   mt_we    in   1   mthi/mtlo write
//   op       in   3   operation select (md_op_e encoding)
//   rs_data  in  32   rs operand / mt source
//   rt_data  in  32   rt operand
//   busy     out  1   operation in flight
//   hi       out 32   HI register
//   lo       out 32   LO register
//
// state   | meaning
// ST_IDLE | accepts start or mthi/mtlo; HI/LO stable
// ST_RUN  | counting down the busy window; commits shadow on terminal count
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mt_we,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      shadow_hi;
  logic [31:0]      shadow_lo;
  logic             wb_en;

  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        div_zero;
  logic        is_calc;
  logic        is_div;

  md_arith u_arith (
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  assign is_calc = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  assign is_div  = (op == MD_DIV) || (op == MD_DIVU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      shadow_hi <= 32'd0;
      shadow_lo <= 32'd0;
      wb_en     <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          // start wins over a simultaneous mt_we even when its op is not a calc op
          if (start) begin
            if (is_calc) begin
              state     <= ST_RUN;
              busy      <= 1'b1;
              cnt       <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
              shadow_hi <= hi_res;
              shadow_lo <= lo_res;
              wb_en     <= !div_zero;  // divide by zero leaves HI/LO untouched
            end
          end else if (mt_we) begin
            if (op == MD_MTHI) hi <= rs_data;
            else if (op == MD_MTLO) lo <= rs_data;
          end
        end
        ST_RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (wb_en) begin
              hi <= shadow_hi;
              lo <= shadow_lo;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mt_we = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic allow_illegal = 1'b0;

  // model of the architectural HI/LO
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  vec_t vecs[$];

  mul_div_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mt_we   (mt_we),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // issue while busy is illegal except where a test provokes it deliberately
  always @(posedge clk) begin
    if (rst_n && busy && (start || mt_we) && !allow_illegal) begin
      errors++;
      $display("FAIL illegal_issue: start=%0b mt_we=%0b while busy, required none", start, mt_we);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the operation definitions.
  function automatic void ref_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l);
    int sa, sb;
    longint p, q, r;
    longint unsigned pu;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin p = longint'(sa) * longint'(sb); h = p[63:32]; l = p[31:0]; end
      3'd1: begin pu = longint'({32'd0, a}) * longint'({32'd0, b}); h = pu[63:32]; l = pu[31:0]; end
      3'd2: if (b != 0) begin
              q = longint'(sa) / longint'(sb);
              r = longint'(sa) % longint'(sb);
              h = r[31:0]; l = q[31:0];
            end
      3'd3: if (b != 0) begin h = a % b; l = a / b; end
      default: ;
    endcase
  endfunction

  task automatic run_calc(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int n, exp_n;
    bit hold_ok;
    eh = m_hi;
    el = m_lo;
    ref_calc(o, a, b, eh, el);
    exp_n = (o < 3'd2) ? 5 : 10;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    hold_ok = 1'b1;
    while (busy && n < 50) begin
      n++;
      if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
      @(negedge clk);
    end
    check({name, "_cycles"}, 32'(n), 32'(exp_n));
    check({name, "_hold"}, {31'd0, hold_ok}, 32'd1);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  // a pulse that must not change anything
  task automatic no_effect(input string name, input logic st, input logic mt, input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    start = st; mt_we = mt; op = o; rs_data = a; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0; mt_we = 1'b0;
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_hi"}, hi, m_hi);
    check({name, "_lo"}, lo, m_lo);
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    mt_we = 1'b1; op = o; rs_data = a;
    @(negedge clk);
    mt_we = 1'b0;
    if (o == 3'd4) m_hi = a; else m_lo = a;
    check("mt_busy", {31'd0, busy}, 32'd0);
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  initial begin
    int n;
    bit ok;
    logic [31:0] eh, el;

    vecs.push_back('{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
    vecs.push_back('{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 5});
    vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
    vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10});
    vecs.push_back('{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10});
    vecs.push_back('{3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10});
    vecs.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5});

    // reset state
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors: each record carries its own expected HI/LO and busy length
    foreach (vecs[i]) begin
      @(negedge clk);
      start = 1'b1; op = vecs[i].op; rs_data = vecs[i].rs; rt_data = vecs[i].rt;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      ok = 1'b1;
      while (busy && n < 50) begin
        n++;
        if (hi !== m_hi || lo !== m_lo) ok = 1'b0;
        @(negedge clk);
      end
      check($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cycles));
      check($sformatf("vec%0d_hold", i), {31'd0, ok}, 32'd1);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      m_hi = vecs[i].exp_hi;
      m_lo = vecs[i].exp_lo;
    end

    // back-to-back MTHI / MTLO, then DIVU by zero keeps them
    @(negedge clk);
    mt_we = 1'b1; op = 3'd4; rs_data = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    op = 3'd5; rs_data = 32'h9ABC_DEF0;
    @(negedge clk);
    mt_we = 1'b0;
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi", hi, 32'h1234_5678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;
    run_calc("divu0", 3'd3, 32'hDEAD_BEEF, 32'd0);
    check("divu0_keep_hi", hi, 32'h1234_5678);
    check("divu0_keep_lo", lo, 32'h9ABC_DEF0);
    run_calc("div0", 3'd2, 32'h8000_0000, 32'd0);

    // reset in the third busy cycle of a DIV
    @(negedge clk);
    start = 1'b1; op = 3'd2; rs_data = 32'd1000; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (14) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) ok = 1'b0;
    end
    check("abort_no_late_wb", {31'd0, ok}, 32'd1);

    // start/mt_we pulsed during a MULT run are ignored
    eh = m_hi;
    el = m_lo;
    ref_calc(3'd0, 32'h0000_1234, 32'hFFFF_0001, eh, el);
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs_data = 32'h0000_1234; rt_data = 32'hFFFF_0001;
    @(negedge clk);
    start = 1'b0;
    allow_illegal = 1'b1;
    n = 0;
    ok = 1'b1;
    while (busy && n < 50) begin
      n++;
      if (hi !== m_hi || lo !== m_lo) ok = 1'b0;
      if (n == 2) begin start = 1'b1; op = 3'd2; rs_data = 32'd77; rt_data = 32'd5; end
      if (n == 3) begin start = 1'b0; mt_we = 1'b1; op = 3'd4; rs_data = 32'hDEAD_BEEF; end
      if (n == 4) mt_we = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    mt_we = 1'b0;
    allow_illegal = 1'b0;
    check("ign_cycles", 32'(n), 32'd5);
    check("ign_hold", {31'd0, ok}, 32'd1);
    check("ign_hi", hi, eh);
    check("ign_lo", lo, el);
    m_hi = eh;
    m_lo = el;
    no_effect("ign_after", 1'b0, 1'b0, 3'd0, 32'd0);

    // priority and reserved encodings
    no_effect("start_mthi", 1'b1, 1'b0, 3'd4, 32'h5555_5555);
    no_effect("mt_mult", 1'b0, 1'b1, 3'd0, 32'h6666_6666);
    no_effect("rsv6_start", 1'b1, 1'b0, 3'd6, 32'h7777_7777);
    no_effect("rsv7_mt", 1'b0, 1'b1, 3'd7, 32'h8888_8888);
    no_effect("start_mt_pri", 1'b1, 1'b1, 3'd5, 32'h9999_9999);

    // randomized traffic against the reference model
    for (int k = 0; k < 40; k++) begin
      int sel;
      logic [31:0] a, b;
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (sel < 4) run_calc($sformatf("rnd%0d", k), 3'(sel), a, b);
      else if (sel < 6) do_mt(3'(sel), a);
      else if (sel == 6) no_effect("rnd_st_mt", 1'b1, 1'b0, 3'(4 + $urandom_range(0, 1)), a);
      else if (sel == 7) no_effect("rnd_mt_calc", 1'b0, 1'b1, 3'($urandom_range(0, 3)), a);
      else no_effect("rnd_rsv", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'(6 + $urandom_range(0, 1)), a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the MIPS pipeline.
- Executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers.
- Exports `busy` and `start`; the hazard unit ORs them to stall any D-stage mt/mf/mcalc instruction.
- `hi`/`lo` are read combinationally by mfhi/mflo in E.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu after the start cycle.
- DIV_CYCLES, 10, busy cycles for div/divu after the start cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  E-stage instruction is mult/multu/div/divu; single-cycle pulse.
- mt_we  input  1  E-stage instruction is mthi/mtlo.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; others reserved.
- rs_data  input  32  forwarded rs operand (dividend / multiplicand / mt source).
- rt_data  input  32  forwarded rt operand (divisor / multiplier).
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async, rst_n=0): `busy`=0, `hi`=0, `lo`=0, counter=0, shadow result=0. Reset mid-operation aborts the operation; HI/LO stay 0 after release.
- Two states, IDLE and RUN.
  - IDLE & start & op in {0..3} → RUN.
    - Counter loads MUL_CYCLES for op 0/1, DIV_CYCLES for op 2/3.
    - Operands are latched.
    - The full 64-bit result is computed into the shadow registers on this edge.
  - RUN: counter decrements each cycle.
    - At the edge where the counter goes 1→0, shadow results are copied into HI/LO and the state returns to IDLE.
- Timing: `busy`=1 on exactly MUL_CYCLES / DIV_CYCLES consecutive cycles, starting the cycle after `start`. New HI/LO are visible in the first cycle with `busy`=0.
- HI/LO keep their old values throughout RUN.
- MULT: signed 32x32 → 64; HI=[63:32], LO=[31:0].
- MULTU: same, unsigned.
- DIV: signed. LO=quotient truncated toward zero; HI=remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU: unsigned.
- Divide by zero (rt_data=0, op 2/3): the busy sequence runs normally; HI and LO keep their previous values.
- MTHI/MTLO: with mt_we=1 and IDLE, `hi` (or `lo`) ← rs_data on the same clock edge, with no busy period.
- start or mt_we while RUN: ignored, no state change. The hazard unit guarantees this never happens; the bench flags it as an assertion.
- start and mt_we in the same cycle: illegal; start takes priority.
- Reserved op codes with start or mt_we: no effect.
- start with op 4/5, or mt_we with op 0..3: no effect.

Decomposition:
- Shared package:
  - op encodings MD_MULT..MD_MTLO;
  - MUL_CYCLES/DIV_CYCLES defaults;
  - the state encoding (IDLE/RUN).
- One natural sub-module: md_arith.
  - Purely combinational; takes op, rs_data, rt_data.
  - Produces hi_res/lo_res and a div_zero flag.
- mul_div_unit keeps the FSM, counter, operand/shadow registers and HI/LO.

Test Plan:
1. MULT: rs=0xFFFFFFFE (-2), rt=0x00000003, start 1 cycle → `busy` high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. MULTU: same operands → HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
3. DIV: rs=0xFFFFFFF9 (-7), rt=2 → `busy` 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
4. MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → `hi`/`lo` updated the cycle after each; `busy` stays 0. DIVU by 0 then → 10 busy cycles, HI/LO unchanged.
5. rst_n pulled low in RUN cycle 3 of a DIV → `busy`, `hi` and `lo` drop to 0 immediately (async); after release, IDLE with no late writeback.
6. start/mt_we pulsed during RUN of a MULT → ignored; the original MULT result commits on schedule.
